// File: rtl/weight_load_scheduler_pkg.sv
// Shared definitions for the weight-tile load scheduler: FSM encodings and
// the weight-memory read latency.
package weight_load_scheduler_pkg;

   typedef enum logic [1:0] {
      WLS_IDLE = 2'd0,
      WLS_LOAD = 2'd1,
      WLS_DONE = 2'd2
   } wls_state_t;

   // Cycles from a registered read strobe on wm_* to the matching word on
   // wm_dout: the word is present in the cycle in which wm_ce is high.
   localparam int WM_RD_LATENCY = 1;

endpackage

// File: rtl/weight_load_scheduler_wmem_port_arbiter.sv
// Weight-memory port mux: the host owns the port while the scheduler is
// idle, the loader owns it otherwise. All wm_* outputs are registered.
module wmem_port_arbiter #(
   parameter int ADDRESS_SIZE_WMEMORY = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            host_sel,
   input  logic                            host_req,
   input  logic                            host_we,
   input  logic [ADDRESS_SIZE_WMEMORY-1:0] host_addr,
   output logic                            host_gnt,
   input  logic                            ld_rd,
   input  logic [ADDRESS_SIZE_WMEMORY-1:0] ld_addr,
   output logic                            wm_ce,
   output logic                            wm_we,
   output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address
);

   // The host is granted in the same cycle it asks, but only while idle.
   always_comb begin
      host_gnt = host_sel & host_req;
   end

   // Register the selected requester onto the memory port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wm_ce      <= 1'b0;
         wm_we      <= 1'b0;
         wm_address <= '0;
      end else if (host_sel) begin
         wm_ce      <= host_req;
         wm_we      <= host_we;
         wm_address <= host_addr;
      end else if (ld_rd) begin
         wm_ce      <= 1'b1;
         wm_we      <= 1'b0;
         wm_address <= ld_addr;
      end else begin
         wm_ce      <= 1'b0;
         wm_we      <= 1'b0;
      end
   end

endmodule

// File: rtl/weight_load_scheduler.sv
// Weight-tile load scheduler: reads ROWS consecutive words from weight
// memory starting at base_addr and hands them to the MXU one row at a time.
//
// wt_valid/wt_ready: a row transfers on every rising edge where both are
// high. Once wt_valid rises it stays high, with wt_data/wt_row stable, until
// that transfer happens; wt_valid never depends combinationally on wt_ready.
module weight_load_scheduler
   import weight_load_scheduler_pkg::*;
#(
   parameter int ROWS                 = 3,
   parameter int COLUMNS              = 3,
   parameter int DATA_WIDTH_WMEMORY   = 64,
   parameter int ADDRESS_SIZE_WMEMORY = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            load_start,
   input  logic                            load_abort,
   input  logic [ADDRESS_SIZE_WMEMORY-1:0] base_addr,
   output logic                            load_busy,
   output logic                            load_done,
   input  logic                            host_req,
   input  logic                            host_we,
   input  logic [ADDRESS_SIZE_WMEMORY-1:0] host_addr,
   output logic                            host_gnt,
   output logic                            wm_ce,
   output logic                            wm_we,
   output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
   input  logic [DATA_WIDTH_WMEMORY-1:0]   wm_dout,
   output logic                            wt_valid,
   output logic [DATA_WIDTH_WMEMORY-1:0]   wt_data,
   output logic [$clog2(ROWS)+1-1:0]       wt_row,
   input  logic                            wt_ready,
   output logic [1:0]                      dbg_state
);

   localparam int CW = $clog2(ROWS) + 1;

   // A row word must hold at least one bit per column.
   if (COLUMNS < 1 || COLUMNS > DATA_WIDTH_WMEMORY) begin : g_bad_columns
      $error("COLUMNS must be in 1..DATA_WIDTH_WMEMORY");
   end

   wls_state_t                      state, state_nxt;
   logic [ADDRESS_SIZE_WMEMORY-1:0] base_q;
   logic [CW-1:0]                   issue_cnt;
   logic [CW-1:0]                   accept_cnt;
   logic [WM_RD_LATENCY-1:0]        pend_sr;
   logic                            pending;
   logic                            capture;
   logic                            accept;
   logic                            issue;
   logic                            hs;
   logic                            last_hs;
   logic                            in_load;
   logic [ADDRESS_SIZE_WMEMORY-1:0] ld_addr;

   // Control decode shared by the FSM, the datapath and the port mux.
   always_comb begin
      in_load = (state == WLS_LOAD);
      pending = |pend_sr;
      capture = pend_sr[WM_RD_LATENCY-1];
      accept  = (state == WLS_IDLE) && load_start && !host_req;
      hs      = wt_valid && wt_ready;
      issue   = in_load && !load_abort && (issue_cnt < CW'(ROWS)) &&
                !pending && (!wt_valid || wt_ready);
      last_hs = in_load && !load_abort && hs && (accept_cnt == CW'(ROWS - 1));
      ld_addr = base_q + ADDRESS_SIZE_WMEMORY'(issue_cnt);
      dbg_state = state;
   end

   // Next-state logic; abort wins over completion.
   always_comb begin
      state_nxt = state;
      case (state)
         WLS_IDLE: if (accept) state_nxt = WLS_LOAD;
         WLS_LOAD: begin
            if (load_abort)   state_nxt = WLS_IDLE;
            else if (last_hs) state_nxt = WLS_DONE;
         end
         WLS_DONE: state_nxt = WLS_IDLE;
         default:  state_nxt = WLS_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WLS_IDLE;
      else       state <= state_nxt;
   end

   // Tile counters, read pipeline, output row register and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q     <= '0;
         issue_cnt  <= '0;
         accept_cnt <= '0;
         pend_sr    <= '0;
         wt_valid   <= 1'b0;
         wt_data    <= '0;
         wt_row     <= '0;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         load_done <= 1'b0;
         if (accept) begin
            base_q     <= base_addr;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            pend_sr    <= '0;
            load_busy  <= 1'b1;
         end
         if (in_load) begin
            if (load_abort) begin
               // Any read still in flight is dropped with the pipeline.
               wt_valid  <= 1'b0;
               pend_sr   <= '0;
               load_busy <= 1'b0;
            end else begin
               pend_sr <= (pend_sr << 1) | WM_RD_LATENCY'(issue);
               if (issue) issue_cnt  <= issue_cnt + CW'(1);
               if (hs)    accept_cnt <= accept_cnt + CW'(1);
               if (capture) begin
                  wt_data  <= wm_dout;
                  wt_row   <= issue_cnt - CW'(1);
                  wt_valid <= 1'b1;
               end else if (hs) begin
                  wt_valid <= 1'b0;
               end
               if (last_hs) begin
                  load_busy <= 1'b0;
                  load_done <= 1'b1;
               end
            end
         end
      end
   end

   wmem_port_arbiter #(
      .ADDRESS_SIZE_WMEMORY(ADDRESS_SIZE_WMEMORY)
   ) u_arb (
      .clk        (clk),
      .reset      (reset),
      .host_sel   (state == WLS_IDLE),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_gnt   (host_gnt),
      .ld_rd      (issue),
      .ld_addr    (ld_addr),
      .wm_ce      (wm_ce),
      .wm_we      (wm_we),
      .wm_address (wm_address)
   );

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Directed bench for weight_load_scheduler with a small weight-memory model.
module tb_weight_load_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_start = 1'b0;
   logic        load_abort = 1'b0;
   logic [31:0] base_addr = '0;
   logic        load_busy;
   logic        load_done;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [31:0] host_addr = '0;
   logic        host_gnt;
   logic        wm_ce;
   logic        wm_we;
   logic [31:0] wm_address;
   logic [63:0] wm_dout;
   logic        wt_valid;
   logic [63:0] wt_data;
   logic [2:0]  wt_row;
   logic        wt_ready = 1'b1;
   logic [1:0]  dbg_state;

   logic [63:0] mem [0:255];
   int          n_checks = 0;
   int          n_fail = 0;

   // Clock and memory model: the word at wm_address is presented while wm_ce is high.
   always #5 clk = ~clk;
   assign wm_dout = mem[wm_address[7:0]];

   weight_load_scheduler dut (
      .clk(clk), .reset(reset), .load_start(load_start), .load_abort(load_abort),
      .base_addr(base_addr), .load_busy(load_busy), .load_done(load_done),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_gnt(host_gnt), .wm_ce(wm_ce), .wm_we(wm_we), .wm_address(wm_address),
      .wm_dout(wm_dout), .wt_valid(wt_valid), .wt_data(wt_data), .wt_row(wt_row),
      .wt_ready(wt_ready), .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full tile load at wt_ready=1; optionally keeps host_req high throughout.
   task automatic load_full(input logic [31:0] base, input logic host_busy, input string tag);
      logic [31:0] a;
      base_addr  = base;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      host_req   = host_busy;
      host_we    = 1'b0;
      host_addr  = 32'h77;
      chk({tag, ".busy"}, 64'(load_busy), 64'd1);
      chk({tag, ".state_load"}, 64'(dbg_state), 64'd1);
      for (int r = 0; r < 3; r++) begin
         a = base + 32'(r);
         tick();
         chk({tag, ".rd_ce"}, 64'(wm_ce), 64'd1);
         chk({tag, ".rd_we"}, 64'(wm_we), 64'd0);
         chk({tag, ".rd_addr"}, 64'(wm_address), 64'(a));
         chk({tag, ".gnt_off"}, 64'(host_gnt), 64'd0);
         tick();
         chk({tag, ".valid"}, 64'(wt_valid), 64'd1);
         chk({tag, ".data"}, wt_data, mem[a[7:0]]);
         chk({tag, ".row"}, 64'(wt_row), 64'(r));
         chk({tag, ".ce_idle"}, 64'(wm_ce), 64'd0);
         chk({tag, ".no_done"}, 64'(load_done), 64'd0);
      end
      tick();
      chk({tag, ".done"}, 64'(load_done), 64'd1);
      chk({tag, ".busy_off"}, 64'(load_busy), 64'd0);
      chk({tag, ".state_done"}, 64'(dbg_state), 64'd2);
      chk({tag, ".gnt_done"}, 64'(host_gnt), 64'd0);
      host_req = 1'b0;
      tick();
      chk({tag, ".done_pulse"}, 64'(load_done), 64'd0);
      chk({tag, ".state_idle"}, 64'(dbg_state), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, 8'(i), 24'hBEEF00, ~8'(i)};
      mem[8'h10] = 64'hAAAA_AAAA_0000_0001;
      mem[8'h11] = 64'hBBBB_BBBB_0000_0002;
      mem[8'h12] = 64'hCCCC_CCCC_0000_0003;

      // 1. Asynchronous reset mid-cycle, then a host write in idle.
      #12 reset = 1'b1;
      #1;
      chk("rst.busy", 64'(load_busy), 64'd0);
      chk("rst.done", 64'(load_done), 64'd0);
      chk("rst.valid", 64'(wt_valid), 64'd0);
      chk("rst.data", wt_data, 64'd0);
      chk("rst.row", 64'(wt_row), 64'd0);
      chk("rst.ce", 64'(wm_ce), 64'd0);
      chk("rst.we", 64'(wm_we), 64'd0);
      chk("rst.addr", 64'(wm_address), 64'd0);
      chk("rst.state", 64'(dbg_state), 64'd0);
      #14 reset = 1'b0;
      tick();
      host_req = 1'b1; host_we = 1'b1; host_addr = 32'd5;
      #1;
      chk("host.gnt", 64'(host_gnt), 64'd1);
      tick();
      chk("host.ce", 64'(wm_ce), 64'd1);
      chk("host.we", 64'(wm_we), 64'd1);
      chk("host.addr", 64'(wm_address), 64'd5);
      host_req = 1'b0; host_we = 1'b0;
      tick();
      chk("host.ce_off", 64'(wm_ce), 64'd0);

      // 2. Full load at base 0x10.
      load_full(32'h10, 1'b0, "full");

      // 3. Backpressure after row 0.
      base_addr = 32'h20; load_start = 1'b1;
      tick();
      load_start = 1'b0;
      tick();
      chk("bp.addr0", 64'(wm_address), 64'h20);
      tick();
      chk("bp.valid0", 64'(wt_valid), 64'd1);
      wt_ready = 1'b0; host_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp.hold_valid", 64'(wt_valid), 64'd1);
         chk("bp.hold_data", wt_data, mem[8'h20]);
         chk("bp.hold_row", 64'(wt_row), 64'd0);
         chk("bp.no_issue", 64'(wm_ce), 64'd0);
         chk("bp.no_gnt", 64'(host_gnt), 64'd0);
      end
      wt_ready = 1'b1;
      tick();
      chk("bp.resume_ce", 64'(wm_ce), 64'd1);
      chk("bp.resume_addr", 64'(wm_address), 64'h21);
      chk("bp.valid_drop", 64'(wt_valid), 64'd0);
      tick();
      chk("bp.data1", wt_data, mem[8'h21]);
      chk("bp.row1", 64'(wt_row), 64'd1);
      tick();
      chk("bp.addr2", 64'(wm_address), 64'h22);
      tick();
      chk("bp.data2", wt_data, mem[8'h22]);
      tick();
      chk("bp.done", 64'(load_done), 64'd1);
      host_req = 1'b0;
      tick();

      // 4. Host and load_start together: host wins, load is dropped.
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'h99;
      base_addr = 32'h40; load_start = 1'b1;
      #1;
      chk("cont.gnt", 64'(host_gnt), 64'd1);
      tick();
      load_start = 1'b0; host_req = 1'b0;
      chk("cont.busy", 64'(load_busy), 64'd0);
      chk("cont.state", 64'(dbg_state), 64'd0);
      chk("cont.addr", 64'(wm_address), 64'h99);
      tick();
      chk("cont.still_idle", 64'(dbg_state), 64'd0);
      load_full(32'h40, 1'b1, "hostload");

      // 5. Abort with the row 1 read in flight, then a clean reload.
      base_addr = 32'h30; load_start = 1'b1;
      tick();
      load_start = 1'b0;
      tick();
      tick();
      tick();
      chk("abort.rd1_ce", 64'(wm_ce), 64'd1);
      chk("abort.rd1_addr", 64'(wm_address), 64'h31);
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      chk("abort.valid", 64'(wt_valid), 64'd0);
      chk("abort.busy", 64'(load_busy), 64'd0);
      chk("abort.state", 64'(dbg_state), 64'd0);
      chk("abort.ce", 64'(wm_ce), 64'd0);
      chk("abort.no_done", 64'(load_done), 64'd0);
      tick();
      chk("abort.discard", 64'(wt_valid), 64'd0);
      chk("abort.no_done2", 64'(load_done), 64'd0);
      load_full(32'h50, 1'b0, "reload");

      // 6. Address wrap at the top of the address space.
      load_full(32'hFFFF_FFFF, 1'b0, "wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_load_scheduler.md
Name: weight_load_scheduler

Overview:
- Sequences transfer of one weight tile (ROWS words, one row of COLUMNS weights each) from the weight memory into the MXU weight-load port.
- Arbitrates the single weight-memory port between the host write path and the loader.
- Started by the control unit before compute. Reports busy/done back to it.

Parameters:
ROWS, 3, MXU rows; number of weight words per tile
COLUMNS, 3, MXU columns; weights packed per word (informational, width check only)
DATA_WIDTH_WMEMORY, 64, weight-memory word width
ADDRESS_SIZE_WMEMORY, 32, weight-memory address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
load_start  in  1  pulse from control unit; begin tile load
load_abort  in  1  cancel an in-progress load
base_addr  in  ADDRESS_SIZE_WMEMORY  first word address of the tile, sampled on accepted load_start
load_busy  out  1  high from accept to completion or abort
load_done  out  1  one-cycle pulse after the last row is accepted by the MXU
host_req  in  1  host requests the memory port
host_we  in  1  host write enable
host_addr  in  ADDRESS_SIZE_WMEMORY  host address
host_gnt  out  1  combinational grant; host access is performed this cycle
wm_ce  out  1  memory chip enable (registered)
wm_we  out  1  memory write enable (registered)
wm_address  out  ADDRESS_SIZE_WMEMORY  memory address (registered)
wm_dout  in  DATA_WIDTH_WMEMORY  memory read data, valid 1 cycle after wm_ce with wm_we=0
wt_valid  out  1  wt_data holds a row for the MXU
wt_data  out  DATA_WIDTH_WMEMORY  row of weights
wt_row  out  $clog2(ROWS)+1  row index of wt_data
wt_ready  in  1  MXU accepts the row when wt_valid && wt_ready

Behaviour:
- Reset is asynchronous, active-high. It clears all state and outputs to 0: state=IDLE, counters, pending, wt_valid, wt_data, wt_row, wm_*, load_busy, load_done.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - host_gnt = host_req.
  - Next cycle, wm_ce <= host_req, wm_we <= host_we, wm_address <= host_addr.
  - load_start accepted only if !host_req. If both are high, host wins; load_start is ignored and the control unit must re-pulse it.
  - On accept: latch base_addr, issue_cnt=0, accept_cnt=0, load_busy<=1, go to LOAD.
- LOAD:
  - host_gnt = 0 while in LOAD.
  - Issue read when issue_cnt<ROWS && !pending && (!wt_valid || wt_ready):
    - wm_ce<=1, wm_we<=0, wm_address<=base+issue_cnt.
    - pending<=1, issue_cnt++.
  - The cycle after issue (pending=1):
    - wt_data<=wm_dout, wt_row<=issue_cnt-1, wt_valid<=1, pending<=0.
  - Handshake: on wt_valid && wt_ready, accept_cnt++. wt_valid drops unless a new row is captured the same cycle.
  - wt_data and wt_row are held stable while wt_valid && !wt_ready.
  - Throughput: 1 row per 2 cycles at wt_ready=1.
  - Transition: when accept_cnt reaches ROWS (last handshake cycle) -> DONE.
- DONE: load_done<=1 for one cycle, load_busy<=0, return to IDLE. host_gnt = 0 in DONE.
- load_abort (LOAD only, highest priority):
  - Next edge: wt_valid<=0, pending<=0, wm_ce<=0, load_busy<=0, state=IDLE.
  - No load_done is generated.
  - A read already in flight is discarded.
- load_start while busy is ignored.
- Address arithmetic wraps modulo 2^ADDRESS_SIZE_WMEMORY.
- ROWS=1 is legal: single issue, then DONE.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (WLS_IDLE=2'd0, WLS_LOAD=2'd1, WLS_DONE=2'd2);
  - the memory read latency constant WM_RD_LATENCY=1.
- One natural sub-module: wmem_port_arbiter, the host/loader mux plus registered wm_* outputs. Everything else is in the top module.

Test Plan:
1. Reset then idle: reset=1 mid-cycle -> all outputs 0 immediately (async); host_req=1, host_we=1, host_addr=5 -> host_gnt=1; next cycle wm_ce=1, wm_we=1, wm_address=5.
2. Full load, wt_ready=1, ROWS=3, base_addr=0x10, memory[0x10..0x12]=A,B,C -> wm_address 0x10,0x11,0x12 every 2 cycles; wt_data A,B,C with wt_row 0,1,2; load_done single pulse 1 cycle after the last handshake; total 7 cycles from accept.
3. Backpressure: wt_ready=0 for 4 cycles after row 0 valid -> wt_data=A held stable, no second issue, no host grant; resumes with B after wt_ready=1.
4. Contention: host_req and load_start the same cycle -> host_gnt=1, load_busy stays 0; host_req during LOAD -> host_gnt=0 throughout.
5. Abort: load_abort while pending=1 after row 1 issue -> next cycle wt_valid=0, load_busy=0, state IDLE, no load_done; a new load_start then completes normally.
6. Wrap: base_addr=0xFFFFFFFF, ROWS=3 -> addresses 0xFFFFFFFF, 0x0, 0x1.
